// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register map, field positions, FSM states and priority helper
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int STATUS_IE_BIT   = 0;
    localparam int STATUS_MASK_LSB = 8;
    localparam int CAUSE_PEND_LSB  = 8;
    localparam int CAUSE_IDX_LSB   = 2;

    localparam int HANDLER_STRIDE = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        HANDLER = 1'b1
    } cp0_state_e;

    // Highest set bit wins, so the top source has priority.
    function automatic logic [1:0] top_index(input logic [3:0] req);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
                idx = i[1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// rtl/irq_edge_latch.sv - rising-edge capture of level requests into sticky pending bits
module irq_edge_latch #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] irq_i,
    input  logic [N-1:0] clear_i,
    output logic [N-1:0] pending_o
);

    logic [N-1:0] prev_q;
    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;
    logic [N-1:0] rise;

    assign rise = irq_i & ~prev_q;

    // A new edge in the same cycle as a service clear must not be lost.
    assign pending_d = (pending_q & ~clear_i) | rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            prev_q    <= irq_i;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - CP0-style interrupt sequencer with EPC, Status and Cause
module interrupt_controller
    import cp0_pkg::*;
#(
    parameter int          IRQ_COUNT    = 3,
    parameter logic [31:0] HANDLER_BASE = 32'h0000_3000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IRQ_COUNT-1:0] irq,
    input  logic                 retire,
    input  logic [31:0]          nextPc,
    input  logic                 mtc0,
    input  logic                 mfc0,
    input  logic                 eret,
    input  logic [4:0]           cp0Addr,
    input  logic [31:0]          writeData,
    output logic [31:0]          readData,
    output logic                 pcRedirect,
    output logic [31:0]          redirectPc,
    output logic                 inHandler,
    output logic [IRQ_COUNT-1:0] pending
);

    cp0_state_e           state_q;
    logic                 ie_q;
    logic [IRQ_COUNT-1:0] mask_q;
    logic [31:0]          epc_q;
    logic [1:0]           cause_idx_q;
    logic                 in_handler_q;

    logic [IRQ_COUNT-1:0] eligible;
    logic [3:0]           elig_wide;
    logic [1:0]           winner;
    logic                 take;
    logic                 eret_fire;
    logic [IRQ_COUNT-1:0] clear_vec;
    logic [31:0]          handler_pc;
    logic [31:0]          status_word;
    logic [31:0]          cause_word;

    irq_edge_latch #(
        .N(IRQ_COUNT)
    ) u_latch (
        .clk      (clk),
        .rst      (rst),
        .irq_i    (irq),
        .clear_i  (clear_vec),
        .pending_o(pending)
    );

    assign eligible = pending & mask_q;

    always_comb begin
        elig_wide = '0;
        elig_wide[IRQ_COUNT-1:0] = eligible;
    end

    assign winner     = top_index(elig_wide);
    assign handler_pc = HANDLER_BASE + (32'(winner) * 32'(HANDLER_STRIDE));

    // IE is the pre-edge value, so an mtc0 in the same instruction cannot gate entry.
    assign take      = (state_q == IDLE) && retire && ie_q && (|eligible) && !eret;
    assign eret_fire = retire && eret;

    always_comb begin
        clear_vec = '0;
        for (int i = 0; i < IRQ_COUNT; i++) begin
            clear_vec[i] = take && (winner == i[1:0]);
        end
    end

    assign pcRedirect = take || eret_fire;
    assign redirectPc = take      ? handler_pc :
                        eret_fire ? epc_q      : 32'h0;

    always_comb begin
        status_word = '0;
        status_word[STATUS_IE_BIT] = ie_q;
        status_word[STATUS_MASK_LSB +: IRQ_COUNT] = mask_q;
        cause_word = '0;
        cause_word[CAUSE_PEND_LSB +: IRQ_COUNT] = pending;
        cause_word[CAUSE_IDX_LSB +: 2] = cause_idx_q;
    end

    always_comb begin
        readData = 32'h0;
        if (mfc0) begin
            case (cp0Addr)
                CP0_STATUS: readData = status_word;
                CP0_CAUSE:  readData = cause_word;
                CP0_EPC:    readData = epc_q;
                default:    readData = 32'h0;
            endcase
        end
    end

    // Software writes land first; entry/return updates below override EPC and IE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ie_q         <= 1'b0;
            mask_q       <= '1;
            epc_q        <= 32'h0;
            cause_idx_q  <= 2'd0;
            in_handler_q <= 1'b0;
        end else begin
            if (retire && mtc0) begin
                if (cp0Addr == CP0_STATUS) begin
                    ie_q   <= writeData[STATUS_IE_BIT];
                    mask_q <= writeData[STATUS_MASK_LSB +: IRQ_COUNT];
                end else if (cp0Addr == CP0_EPC) begin
                    epc_q <= writeData;
                end
            end
            case (state_q)
                IDLE: begin
                    if (take) begin
                        epc_q        <= nextPc;
                        cause_idx_q  <= winner;
                        ie_q         <= 1'b0;
                        state_q      <= HANDLER;
                        in_handler_q <= 1'b1;
                    end else if (eret_fire) begin
                        ie_q <= 1'b1;
                    end
                end
                HANDLER: begin
                    if (eret_fire) begin
                        ie_q         <= 1'b1;
                        state_q      <= IDLE;
                        in_handler_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inHandler = in_handler_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - scoreboard bench for interrupt_controller against a behavioural model
module tb_interrupt_controller;

    localparam int OP_NONE = 0;
    localparam int OP_MTC0 = 1;
    localparam int OP_MFC0 = 2;
    localparam int OP_ERET = 3;
    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq;
    logic        retire;
    logic [31:0] nextPc;
    logic        mtc0;
    logic        mfc0;
    logic        eret;
    logic [4:0]  cp0Addr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        pcRedirect;
    logic [31:0] redirectPc;
    logic        inHandler;
    logic [2:0]  pending;

    interrupt_controller #(
        .IRQ_COUNT   (3),
        .HANDLER_BASE(BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .retire    (retire),
        .nextPc    (nextPc),
        .mtc0      (mtc0),
        .mfc0      (mfc0),
        .eret      (eret),
        .cp0Addr   (cp0Addr),
        .writeData (writeData),
        .readData  (readData),
        .pcRedirect(pcRedirect),
        .redirectPc(redirectPc),
        .inHandler (inHandler),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        bit          redir;
        logic [31:0] pc;
        logic [31:0] rd;
        bit          inh;
        logic [2:0]  pend;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: architectural state only.
    bit          m_inh;
    bit          m_ie;
    logic [2:0]  m_mask;
    logic [2:0]  m_pend;
    logic [2:0]  m_prev;
    logic [31:0] m_epc;
    logic [1:0]  m_cause;

    task automatic model_reset();
        m_inh   = 1'b0;
        m_ie    = 1'b0;
        m_mask  = 3'b111;
        m_pend  = 3'b000;
        m_prev  = 3'b000;
        m_epc   = 32'h0;
        m_cause = 2'd0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return {21'b0, m_mask, 7'b0, m_ie};
            5'd13:   return {21'b0, m_pend, 4'b0, m_cause, 2'b0};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic drive(input bit r, input logic [2:0] ir, input bit ret, input logic [31:0] npc,
                         input int op, input logic [4:0] a, input logic [31:0] wd);
        exp_t       e;
        logic [2:0] elig;
        logic [2:0] clr;
        int         w;
        bit         take;
        bit         er;
        @(negedge clk);
        rst       = r;
        irq       = ir;
        retire    = ret;
        nextPc    = npc;
        mtc0      = (op == OP_MTC0);
        mfc0      = (op == OP_MFC0);
        eret      = (op == OP_ERET);
        cp0Addr   = a;
        writeData = wd;

        elig = m_pend & m_mask;
        w = 0;
        for (int i = 0; i < 3; i++) if (elig[i]) w = i;
        take = !m_inh && ret && m_ie && (elig != 3'b000) && (op != OP_ERET);
        er   = ret && (op == OP_ERET);

        e.chk   = !r;
        e.redir = take || er;
        e.pc    = take ? BASE + 32'(16 * w) : (er ? m_epc : 32'h0);
        e.rd    = (op == OP_MFC0) ? model_read(a) : 32'h0;
        e.inh   = m_inh;
        e.pend  = m_pend;
        exp_q.push_back(e);

        if (r) begin
            model_reset();
        end else begin
            clr    = take ? (3'b001 << w) : 3'b000;
            m_pend = (m_pend & ~clr) | (ir & ~m_prev);
            m_prev = ir;
            if (ret && op == OP_MTC0) begin
                if (a == 5'd12) begin
                    m_ie   = wd[0];
                    m_mask = wd[10:8];
                end else if (a == 5'd14) begin
                    m_epc = wd;
                end
            end
            if (take) begin
                m_epc   = npc;
                m_cause = w[1:0];
                m_ie    = 1'b0;
                m_inh   = 1'b1;
            end
            if (er) begin
                m_ie  = 1'b1;
                m_inh = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n, input logic [2:0] ir);
        for (int i = 0; i < n; i++) drive(0, ir, 0, 32'h0, OP_NONE, 5'd0, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    check("pcRedirect", {31'b0, pcRedirect}, {31'b0, e.redir});
                    check("redirectPc", redirectPc, e.pc);
                    check("readData", readData, e.rd);
                    check("inHandler", {31'b0, inHandler}, {31'b0, e.inh});
                    check("pending", {29'b0, pending}, {29'b0, e.pend});
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [2:0]  cur;
        logic [4:0]  a;
        logic [31:0] wd;
        int          op;
        int          pick;
        model_reset();
        rst = 1'b1; irq = '0; retire = 0; nextPc = '0; mtc0 = 0; mfc0 = 0; eret = 0;
        cp0Addr = '0; writeData = '0;

        drive(1, 0, 0, 0, OP_NONE, 0, 0);
        drive(1, 0, 0, 0, OP_NONE, 0, 0);
        drive(0, 0, 0, 0, OP_MFC0, 5'd12, 0);

        // Enable, single source, entry and EPC capture
        drive(0, 3'b000, 1, 32'h4, OP_MTC0, 5'd12, 32'h0000_0701);
        drive(0, 3'b010, 0, 0, OP_NONE, 0, 0);
        idle(1, 3'b000);
        drive(0, 3'b000, 1, 32'h40, OP_NONE, 0, 0);
        drive(0, 3'b000, 0, 0, OP_MFC0, 5'd14, 0);

        // Accumulate in handler, return, then immediate re-entry
        drive(0, 3'b001, 0, 0, OP_NONE, 0, 0);
        drive(0, 3'b000, 1, 32'h80, OP_ERET, 0, 0);
        drive(0, 3'b000, 1, 32'h44, OP_NONE, 0, 0);
        drive(0, 3'b000, 1, 32'h3004, OP_ERET, 0, 0);

        // Simultaneous rises: priority order
        drive(0, 3'b101, 0, 0, OP_NONE, 0, 0);
        idle(1, 3'b000);
        drive(0, 3'b000, 1, 32'h100, OP_NONE, 0, 0);
        drive(0, 3'b000, 1, 32'h3020, OP_ERET, 0, 0);
        drive(0, 3'b000, 1, 32'h104, OP_NONE, 0, 0);
        drive(0, 3'b000, 1, 32'h3000, OP_ERET, 0, 0);

        // Masked source stays pending until unmasked
        drive(0, 3'b000, 1, 32'h8, OP_MTC0, 5'd12, 32'h0000_0501);
        drive(0, 3'b010, 0, 0, OP_NONE, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 3'b000, 1, 32'h200 + 32'(4 * i), OP_NONE, 0, 0);
        drive(0, 3'b000, 0, 0, OP_MFC0, 5'd13, 0);
        drive(0, 3'b000, 1, 32'h240, OP_MTC0, 5'd12, 32'h0000_0701);
        drive(0, 3'b000, 1, 32'h244, OP_NONE, 0, 0);
        drive(0, 3'b000, 1, 32'h3010, OP_ERET, 0, 0);

        // No retire, no entry; then reset from inside the handler
        drive(0, 3'b100, 0, 0, OP_NONE, 0, 0);
        idle(5, 3'b100);
        drive(0, 3'b100, 1, 32'h300, OP_NONE, 0, 0);
        drive(0, 3'b011, 0, 0, OP_NONE, 0, 0);
        drive(1, 3'b000, 0, 0, OP_NONE, 0, 0);
        drive(0, 3'b000, 0, 0, OP_MFC0, 5'd14, 0);
        drive(0, 3'b000, 0, 0, OP_MFC0, 5'd12, 0);

        // Unmapped reads and read-only Cause
        drive(0, 3'b000, 1, 32'h10, OP_MTC0, 5'd12, 32'h0000_0701);
        drive(0, 3'b001, 1, 32'h14, OP_NONE, 0, 0);
        drive(0, 3'b000, 1, 32'h18, OP_NONE, 0, 0);
        drive(0, 3'b000, 0, 0, OP_MFC0, 5'd14, 0);
        drive(0, 3'b000, 0, 0, OP_MFC0, 5'd7, 0);
        drive(0, 3'b000, 1, 32'h1c, OP_MTC0, 5'd13, 32'hFFFF_FFFF);
        drive(0, 3'b000, 0, 0, OP_MFC0, 5'd13, 0);
        drive(0, 3'b000, 1, 32'h3000, OP_ERET, 0, 0);

        // Randomised traffic
        cur = 3'b000;
        for (int n = 0; n < 3000; n++) begin
            cur  = cur ^ (($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000);
            pick = $urandom_range(0, 19);
            op   = (pick < 2) ? OP_MTC0 : (pick < 5) ? OP_MFC0 : (pick < 7) ? OP_ERET : OP_NONE;
            case ($urandom_range(0, 4))
                0, 1:    a = 5'd12;
                2:       a = 5'd13;
                3:       a = 5'd14;
                default: a = 5'($urandom);
            endcase
            wd = $urandom;
            if (op == OP_MTC0 && a == 5'd12 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            drive(($urandom_range(0, 399) == 0), cur, ($urandom_range(0, 9) < 7),
                  $urandom & 32'hFFFF_FFFC, op, a, wd);
        end
        idle(2, 3'b000);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Coprocessor-0-style interrupt sequencer for the single-cycle MIPS core.
- Latches external interrupt requests and arbitrates them by fixed priority.
- At an instruction boundary it redirects the PC to a per-source handler and saves the EPC.
- Serves the mtc0/mfc0/eret control lines that the instruction decoder already produces.

Parameters:
IRQ_COUNT, 3, number of interrupt sources (1..4)
HANDLER_BASE, 32'h0000_3000, handler address for source 0; source i vectors to HANDLER_BASE + i*16

Ports:
clk  input  1  core clock
rst  input  1  reset; synchronous, active-high
irq  input  IRQ_COUNT  raw level interrupt requests, already synchronised to clk
retire  input  1  an instruction completes at this clock edge
nextPc  input  32  PC the core would load at this edge without redirect
mtc0  input  1  retiring instruction is mtc0
mfc0  input  1  retiring instruction is mfc0
eret  input  1  retiring instruction is eret
cp0Addr  input  5  CP0 register number (rd field)
writeData  input  32  rt value for mtc0
readData  output  32  CP0 register value for mfc0 (combinational)
pcRedirect  output  1  core must load redirectPc instead of nextPc at this edge
redirectPc  output  32  redirect target
inHandler  output  1  FSM is in HANDLER
pending  output  IRQ_COUNT  latched, not-yet-serviced requests

Behaviour:
- Reset (rst high at an edge):
  - state IDLE; pending 0; IE 0; mask all 1s; EPC 0; cause source 0; irq history 0.
  - Outputs: pcRedirect 0, redirectPc 0, inHandler 0, readData 0.
  - Reset mid-handler returns to IDLE and discards pending requests.
- Edge latch: irq is registered each cycle. A rising edge on bit i (irq[i] & ~prev[i]) sets pending[i] at the next edge. pending[i] clears only when source i is taken. If a set and a clear of the same bit occur in the same cycle, set wins.
- CP0 registers (other addresses read 0; writes to them are ignored):
  - 12 Status: bit0 IE, bits[8+IRQ_COUNT-1:8] mask. Read/write.
  - 13 Cause: bits[8+IRQ_COUNT-1:8] mirror pending; bits[3:2] index of the last taken source. Read-only.
  - 14 EPC: read/write.
- mtc0 writes at the edge when mtc0 & retire. readData = register[cp0Addr] whenever mfc0 is high; otherwise 0.
- Arbitration:
  - eligible = pending & mask.
  - The winner is the highest set index, so irq[IRQ_COUNT-1] has top priority.
- FSM IDLE:
  - When retire & IE & |eligible & ~eret, in that same cycle (Mealy output): pcRedirect=1, redirectPc=HANDLER_BASE + winner*16.
  - At the edge: EPC<=nextPc, cause index<=winner, IE<=0, pending[winner] cleared, state<=HANDLER.
  - IE is evaluated before any same-cycle mtc0 write. If an mtc0 to EPC/Status coincides with entry, the entry updates win for EPC and IE; the mask write still applies.
- FSM HANDLER:
  - No nesting; new edges keep accumulating in pending.
  - On retire & eret: pcRedirect=1, redirectPc=EPC (value before any same-cycle write). At the edge: IE<=1, state<=IDLE.
  - An eligible interrupt is taken no earlier than the next retire after that edge.
- eret while IDLE: redirect to EPC, IE<=1, state unchanged.
- retire low: no redirect, no state change, and no CP0 writes. Edge latching continues.
- inHandler = (state == HANDLER), registered.

Decomposition:
- Package cp0_pkg holds:
  - CP0 address constants (STATUS=12, CAUSE=13, EPC=14)
  - Status/Cause bit positions
  - FSM state enum {IDLE, HANDLER}
  - HANDLER_STRIDE=16
- One sub-module, irq_edge_latch: owns the history register, rising-edge detection and the pending set/clear logic, with set-priority. Its inputs are irq and a clear vector; its output is pending.

Test Plan:
1. Reset, then mtc0 Status=32'h0000_0701 with retire; pulse irq[1] for 1 cycle; next retire with nextPc=32'h0000_0040 -> pcRedirect=1, redirectPc=32'h0000_3010; afterwards EPC=32'h40, inHandler=1, pending=3'b000.
2. In HANDLER, pulse irq[0], then retire with eret -> redirectPc=32'h40, IE=1, IDLE. At the next retire -> redirect to 32'h0000_3000 with pending[0] cleared.
3. irq[0] and irq[2] rise in the same cycle, IE=1, mask=3'b111 -> first entry targets 32'h0000_3020; after eret -> second entry targets 32'h0000_3000.
4. Mask=3'b101 with irq[1] pending -> no redirect over 10 retires; Cause bits[10:8]=3'b010. mtc0 mask=3'b111 -> the next retire after the write redirects to 32'h0000_3010.
5. IE=1 with irq[2] pending but retire held low for 5 cycles -> pcRedirect stays 0. Then assert rst mid-HANDLER -> state IDLE, pending 0, IE 0, EPC 0, all outputs 0.
6. mfc0 with cp0Addr=14 after entry -> readData=EPC. cp0Addr=7 -> readData=0. mtc0 to Cause -> Cause unchanged.
